ram_block_copier: RTL

//   Bus initiator for a RAM64-style memory: single clk, synchronous write on load, combinational read.

---
 rtl/ram_block_copier.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ram_block_copier.sv
// ram_block_copier
//   Bus initiator for a RAM64-style memory (synchronous write on load,
//   combinational read). Copies len words from src to dst, or fills len
//   words at dst with a constant. All address arithmetic wraps modulo
//   2**ADDR_W.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             request pulse, only honoured in IDLE
//   mode              0 = copy, 1 = fill (captured at start)
//   src, dst, len     source base, destination base, word count 0..2**ADDR_W
//   fill_value        fill word (captured at start)
//   busy              high while reading/writing
//   done              one-cycle completion pulse
//   words_done        words written in the current or last operation
//   mem_address, mem_load, mem_in   drive the RAM port
//   mem_out           RAM read data (combinational)
module ram_block_copier #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic              mode_r;
    logic [ADDR_W-1:0] src_r, dst_r, addr_r;
    logic [ADDR_W:0]   len_r, count_r;
    logic [DATA_W-1:0] fill_r, data_r;
    logic [ADDR_W-1:0] idx;
    logic              last;

    // The written-word count doubles as the word index.
    assign idx  = count_r[ADDR_W-1:0];
    assign last = (count_r + (ADDR_W+1)'(1)) == len_r;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)   state_next = DONE;
                    else if (mode)   state_next = WRITE;
                    else             state_next = READ;
                end
            end
            READ:  state_next = WRITE;
            WRITE: begin
                if (last)        state_next = DONE;
                else if (mode_r) state_next = WRITE;
                else             state_next = READ;
            end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address register is preloaded one step ahead so mem_address comes
    // straight from a flop and holds its last value in IDLE/DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r  <= 1'b0;
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            fill_r  <= '0;
            data_r  <= '0;
            addr_r  <= '0;
            count_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        src_r   <= src;
                        dst_r   <= dst;
                        len_r   <= len;
                        fill_r  <= fill_value;
                        count_r <= '0;
                        if (len != '0) addr_r <= mode ? dst : src;
                    end
                end
                READ: begin
                    data_r <= mem_out;
                    addr_r <= dst_r + idx;
                end
                WRITE: begin
                    count_r <= count_r + (ADDR_W+1)'(1);
                    if (!last) addr_r <= (mode_r ? dst_r : src_r) + idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state == READ) || (state == WRITE);
        done        = (state == DONE);
        // Reset suppresses a write already in flight on the same edge.
        mem_load    = (state == WRITE) && !reset;
        mem_in      = (state == WRITE) ? (mode_r ? fill_r : data_r) : '0;
        mem_address = addr_r;
        words_done  = count_r;
    end

endmodule
